// File: rtl/morse_pkg.sv
// Shared morse definitions for the keyed-line transmitter and receiver:
// element encoding, timing multipliers and the symbol-to-ASCII decode.
package morse_pkg;

    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    localparam int GLITCH_DIV  = 2;
    localparam int LETTER_MULT = 2;
    localparam int WORD_MULT   = 5;

    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        GAP
    } rx_state_t;

    // Code is sentinel-coded: a leading 1 followed by the elements,
    // oldest element in the most significant position.
    function automatic logic [7:0] code_to_ascii(input logic [6:0] code);
        logic [7:0] c;
        case (code)
            7'd5:    c = "A";
            7'd24:   c = "B";
            7'd26:   c = "C";
            7'd12:   c = "D";
            7'd2:    c = "E";
            7'd18:   c = "F";
            7'd14:   c = "G";
            7'd16:   c = "H";
            7'd4:    c = "I";
            7'd23:   c = "J";
            7'd13:   c = "K";
            7'd20:   c = "L";
            7'd7:    c = "M";
            7'd6:    c = "N";
            7'd15:   c = "O";
            7'd22:   c = "P";
            7'd29:   c = "Q";
            7'd10:   c = "R";
            7'd8:    c = "S";
            7'd3:    c = "T";
            7'd9:    c = "U";
            7'd17:   c = "V";
            7'd11:   c = "W";
            7'd25:   c = "X";
            7'd27:   c = "Y";
            7'd28:   c = "Z";
            7'd63:   c = "0";
            7'd47:   c = "1";
            7'd39:   c = "2";
            7'd35:   c = "3";
            7'd33:   c = "4";
            7'd32:   c = "5";
            7'd48:   c = "6";
            7'd56:   c = "7";
            7'd60:   c = "8";
            7'd62:   c = "9";
            default: c = ASCII_UNKNOWN;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/morse_rx_fifo.sv
// Synchronous show-ahead byte FIFO. Ports: clk, arst_n, push/push_data,
// pop, data (head, 0 when empty), empty, full. Push while full is dropped
// unless a pop happens in the same cycle.
module morse_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] data,
    output logic       empty,
    output logic       full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign data    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/morse_rx.sv
// Morse receiver: times marks/spaces on the synchronized keyed line, builds
// dot/dash symbols, decodes them to ASCII and buffers them in a FIFO.
// Ports: clk, arst_n, morse_in (async), read_en; ascii_out, empty, overflow.
module morse_rx
    import morse_pkg::*;
#(
    parameter int PRESCALER = 100,
    parameter int DEPTH     = 4
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       morse_in,
    input  logic       read_en,
    output logic [7:0] ascii_out,
    output logic       empty,
    output logic       overflow
);

    localparam int RUN_MAX = WORD_MULT * PRESCALER;
    localparam int RW      = $clog2(RUN_MAX + 1);

    localparam logic [RW-1:0] RUN_TOP  = RW'(RUN_MAX);
    localparam logic [RW-1:0] GLITCH_L = RW'(PRESCALER / GLITCH_DIV);
    localparam logic [RW-1:0] LETTER_L = RW'(LETTER_MULT * PRESCALER);

    logic          s1;
    logic          ms;
    logic          lvl;
    logic [RW-1:0] run;
    logic          fall;

    rx_state_t state, state_n;
    logic [6:0] code, code_n;
    logic [2:0] cnt, cnt_n;
    logic       err, err_n;
    logic       wp, wp_n;
    logic       push;
    logic [7:0] push_data;
    logic       full;

    // lvl is the level whose length run is measuring; while ms differs
    // from lvl, run still holds the completed length of the previous level.
    assign fall = lvl & ~ms;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s1  <= 1'b0;
            ms  <= 1'b0;
            lvl <= 1'b0;
            run <= '0;
        end else begin
            s1  <= morse_in;
            ms  <= s1;
            lvl <= ms;
            if (ms != lvl)
                run <= RW'(1);
            else if (run != RUN_TOP)
                run <= run + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
            code  <= 7'd1;
            cnt   <= '0;
            err   <= 1'b0;
            wp    <= 1'b0;
        end else begin
            state <= state_n;
            code  <= code_n;
            cnt   <= cnt_n;
            err   <= err_n;
            wp    <= wp_n;
        end
    end

    always_comb begin
        state_n   = state;
        code_n    = code;
        cnt_n     = cnt;
        err_n     = err;
        wp_n      = wp;
        push      = 1'b0;
        push_data = ASCII_SPACE;
        unique case (state)
            IDLE: begin
                if (ms) state_n = MARK;
            end
            MARK: begin
                if (fall) begin
                    state_n = GAP;
                    if (run < GLITCH_L) begin
                        if (cnt == '0 && !wp) state_n = IDLE;
                    end else if (cnt == 3'd6) begin
                        err_n = 1'b1;
                    end else begin
                        code_n = {code[5:0], (run < LETTER_L) ? DOT : DASH};
                        cnt_n  = cnt + 1'b1;
                    end
                end
            end
            GAP: begin
                if (ms) begin
                    state_n = MARK;
                end else if (!lvl) begin
                    if (run == LETTER_L && cnt != '0) begin
                        push      = 1'b1;
                        push_data = err ? ASCII_UNKNOWN : code_to_ascii(code);
                        code_n    = 7'd1;
                        cnt_n     = '0;
                        err_n     = 1'b0;
                        wp_n      = 1'b1;
                    end else if (run == RUN_TOP && wp) begin
                        push    = 1'b1;
                        wp_n    = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            overflow <= 1'b0;
        else
            overflow <= push & full & ~(read_en & ~empty);
    end

    morse_rx_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .arst_n   (arst_n),
        .push     (push),
        .push_data(push_data),
        .pop      (read_en),
        .data     (ascii_out),
        .empty    (empty),
        .full     (full)
    );

endmodule

// File: doc/morse_rx.md
Name: morse_rx

Overview:
Downstream stage of the morse transmitter. It receives the serial on/off keyed line produced by the transmitter, times marks and spaces in units of PRESCALER clocks, and classifies dots, dashes, letter gaps and word gaps. It decodes each completed symbol to ASCII and buffers the characters in a small FIFO. The read side mirrors the transmitter's write_en/full style (read_en/empty), so a TX→RX loopback reproduces the original text.

Parameters:
PRESCALER, 100, clocks per morse unit; must match the transmitter; must be ≥4.
DEPTH, 4, output FIFO entries; power of two, ≥2.

Ports:
clk  in  1  system clock
arst_n  in  1  asynchronous active-low reset
morse_in  in  1  keyed line, 1 = mark; asynchronous to clk
read_en  in  1  pop request; ignored when empty
ascii_out  out  8  FIFO head (show-ahead); valid when empty=0
empty  out  1  FIFO empty
overflow  out  1  one-cycle pulse when a character is dropped because the FIFO is full

Behaviour:
- Reset values: ascii_out=0x00, empty=1, overflow=0. FSM goes to IDLE; run counter, element buffer and FIFO pointers clear; synchronizer flops clear to 0.
- Synchronizer: morse_in passes through 2 flops (ms). All timing below refers to ms.
- Run counter: counts consecutive clocks at the current ms level.
  - Value is 1 on the first cycle of a new level.
  - Saturates at 5*PRESCALER.
  - Width is clog2(5*PRESCALER+1).
- Mark classification, taken at the falling edge of ms with run length L:
  - L < PRESCALER/2: glitch; no element is appended.
  - L < 2*PRESCALER: dot.
  - Otherwise: dash.
- Element buffer: sentinel-coded, 7 bits. Starts at 0b1; each element shifts left and inserts 0 for a dot, 1 for a dash.
  - An element count of 0 to 6 is tracked.
  - A 7th element sets err and is not stored.
- FSM states:
  - IDLE: ms=0, nothing pending. ms=1 → MARK.
  - MARK: ms=1. Falling edge → GAP with the element appended (or discarded as a glitch). If no elements and no word pending after a glitch → IDLE.
  - GAP: ms=0.
    - ms=1 → MARK; the gap counter is discarded.
    - Low run == 2*PRESCALER with element count > 0: push the decoded char, clear the buffer and err, set word_pending.
    - Low run == 5*PRESCALER with word_pending: push 0x20, clear word_pending → IDLE.
- Emission latency: a pushed char reaches ascii_out and empty=0 on the clock after the push edge, when the FIFO was empty.
- Space rules:
  - No leading space after reset or idle.
  - Never two consecutive spaces.
  - A glitch inside a gap restarts the gap count from the falling edge.
- Decode: A–Z and 0–9 use the standard international codes, uppercase output. An unknown code or err=1 yields '?' (0x3F).
- FIFO:
  - Push while full without a same-cycle pop: char dropped, overflow=1 for one cycle.
  - Push and pop in the same cycle while full: both take effect; no overflow.
  - read_en on empty: no effect.
  - Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
- Reset mid-character: the partial symbol is lost; no output is produced for it.

Decomposition:
- morse_pkg holds everything shared with the transmitter:
  - element encoding constants (DOT=0, DASH=1);
  - threshold multipliers (GLITCH_DIV=2, LETTER_MULT=2, WORD_MULT=5);
  - function code_to_ascii(7-bit sentinel code) → 8-bit, with the '?' default;
  - ASCII_SPACE and ASCII_UNKNOWN constants.
- Sub-module morse_rx_fifo (parameter DEPTH): synchronous show-ahead FIFO with push/pop/empty/full. It is reusable by the transmitter's input buffer.

Test Plan:
- Test 1 (all tests use PRESCALER=100, DEPTH=4): reset; mark 100 clk, then low → 0x45 'E' appears within 3 clk after low run 200; 0x20 appears after low run 500; then nothing more while low.
- Test 2: dot (100), gap (100), dash (300), low 1000 → 'A' (0x41) then ' '. Repeat with the dash at 250 clk → still 'A'.
- Test 3: six dots then low → '?' (0x3F). Seven dots → '?'; no spurious second char; err is cleared for the next letter.
- Test 4: 20-clk high glitch while idle → empty stays 1. A 20-clk glitch 150 clk into a letter gap → no letter emitted at the original 200 mark; the letter is emitted 200 clk after the glitch ends.
- Test 5: read_en=0, five letters separated by 300-clk gaps → first 4 retained in order; overflow pulses 1 cycle on the 5th. Pop with read_en on the same cycle as a full push → no overflow.
- Test 6: loopback from the morse transmitter (PRESCALER=100), which is sent "CARS ARE RED" → read sequence C,A,R,S,' ',A,R,E,' ',R,E,D,' '. Assert arst_n low mid-letter → empty=1 immediately; the next letter decodes correctly.
